vospi_slave: RTL and testbench

- Camera-side VoSPI packet transmitter; the counterpart of vospi_master.
- Accepts a 16-bit pixel stream, buffers it one line at a time, and shifts 164-byte packets out on miso_o under external sclk_i/cs_i.
- When no full line is ready it emits discard packets (ID 16'h0F00).
- Used as a synthesizable sensor emulator for master/pixel_collector bring-up and for FPGA loopback.

---
 rtl/vospi_pkg.sv | 26 ++
 rtl/vospi_line_buffer.sv | 95 +++++++++
 rtl/vospi_slave.sv | 179 +++++++++++++++++
 tb/tb_vospi_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vospi_pkg.sv
// Shared constants and types for the VoSPI slave: packet layout, discard ID,
// packet state encoding and the line-width derivation.
package vospi_pkg;

    localparam int id_hi_ofs_c   = 0;
    localparam int id_lo_ofs_c   = 1;
    localparam int crc_hi_ofs_c  = 2;
    localparam int crc_lo_ofs_c  = 3;
    localparam int payload_ofs_c = 4;
    localparam int hdr_bits_c    = payload_ofs_c * 8;

    localparam logic [15:0] discard_id_c = 16'h0F00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } pkt_state_e;

    function automatic int line_pixels(input int packet_bytes, input int pixel_bytes);
        return (packet_bytes - payload_ofs_c) / pixel_bytes;
    endfunction

    localparam int line_pixels_p = line_pixels(164, 2);

endpackage

// File: rtl/vospi_line_buffer.sv
// Ping-pong line storage: one buffer fills from the pixel stream while the
// other, once full and tagged with its line number, is read by the packetiser.
module vospi_line_buffer
    import vospi_pkg::*;
#(
    parameter int line_pixels_p   = 80,
    parameter int frame_packets_p = 60,
    parameter int col_w           = 7,
    parameter int line_w          = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic              wr_sof_i,
    input  logic [15:0]       wr_data_i,
    input  logic              flush_i,
    input  logic              rd_free_i,
    input  logic [col_w-1:0]  rd_addr_i,
    output logic [15:0]       rd_data_o,
    output logic              rd_full_o,
    output logic [line_w-1:0] rd_tag_o,
    output logic              both_full_o
);

    logic [15:0]       mem [2][line_pixels_p];
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic [line_w-1:0] tag [2];
    logic              wr_sel;
    logic              rd_sel;
    logic [col_w-1:0]  wr_col;
    logic [line_w-1:0] wr_line;
    logic [col_w-1:0]  col_eff;
    logic [line_w-1:0] line_eff;
    logic              line_done;

    // SOF realigns the fill position to line 0, column 0 without touching full buffers
    assign col_eff   = wr_sof_i ? '0 : wr_col;
    assign line_eff  = wr_sof_i ? '0 : wr_line;
    assign line_done = wr_en_i && (col_eff == col_w'(line_pixels_p - 1));

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_sel][col_eff] <= wr_data_i;
        end
    end

    // Free and fill-complete always target different buffers, so both apply together
    always_comb begin
        full_nxt = full;
        if (rd_free_i) begin
            full_nxt[rd_sel] = 1'b0;
        end
        if (line_done) begin
            full_nxt[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            full    <= '0;
            tag     <= '{default: '0};
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_col  <= '0;
            wr_line <= '0;
        end else if (flush_i) begin
            full    <= '0;
            wr_sel  <= 1'b0;
            rd_sel  <= 1'b0;
            wr_col  <= '0;
            wr_line <= '0;
        end else begin
            full <= full_nxt;
            if (rd_free_i) begin
                rd_sel <= ~rd_sel;
            end
            if (line_done) begin
                tag[wr_sel] <= line_eff;
                wr_sel      <= ~wr_sel;
                wr_col      <= '0;
                wr_line     <= (line_eff == line_w'(frame_packets_p - 1)) ? '0 : line_eff + 1'b1;
            end else if (wr_en_i) begin
                wr_col  <= col_eff + 1'b1;
                wr_line <= line_eff;
            end
        end
    end

    assign rd_data_o   = mem[rd_sel][rd_addr_i];
    assign rd_full_o   = full[rd_sel];
    assign rd_tag_o    = tag[rd_sel];
    assign both_full_o = &full;

endmodule

// File: rtl/vospi_slave.sv
// VoSPI sensor emulator: buffers pixel lines and shifts real or discard
// packets out on miso_o under the master's sclk_i/cs_i (SPI mode 3).
module vospi_slave
    import vospi_pkg::*;
#(
    parameter int          packet_bytes_p  = 164,
    parameter int          frame_packets_p = 60,
    parameter int          pixel_bytes_p   = 2,
    parameter logic [15:0] discard_id_p    = discard_id_c
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sclk_i,
    input  logic        cs_i,
    output logic        miso_o,
    input  logic [15:0] pixel_i,
    input  logic        pixel_valid_i,
    input  logic        pixel_sof_i,
    output logic        pixel_ready_o,
    output logic        frame_done_o,
    output logic        busy_o
);

    localparam int line_pixels_p = line_pixels(packet_bytes_p, pixel_bytes_p);
    localparam int total_bits_p  = packet_bytes_p * 8;
    localparam int bit_w         = $clog2(total_bits_p);
    localparam int col_w         = (line_pixels_p > 1) ? $clog2(line_pixels_p) : 1;
    localparam int line_w        = (frame_packets_p > 1) ? $clog2(frame_packets_p) : 1;

    logic [1:0]        sclk_sync;
    logic [1:0]        cs_sync;
    logic              sclk_d;
    logic              sclk_fall;
    logic              cs_s;

    pkt_state_e        state;
    logic [bit_w-1:0]  bit_cnt;
    logic              pkt_real;
    logic [line_w-1:0] pkt_id;
    logic              rd_free;
    logic              flush;
    logic              drop;

    logic              cur_real;
    logic [line_w-1:0] cur_id;
    logic [15:0]       id_word;
    logic              last_bit;
    int                byte_idx;
    int                pay_idx;
    logic [7:0]        tx_byte;
    logic              tx_bit;

    logic [col_w-1:0]  rd_addr;
    logic [15:0]       rd_data;
    logic              rd_full;
    logic [line_w-1:0] rd_tag;
    logic              both_full;
    logic              accept;
    logic              wr_en;

    // Both SPI pins idle high, so the synchronizers reset high to avoid a false fall
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sclk_sync <= 2'b11;
            cs_sync   <= 2'b11;
            sclk_d    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_i};
            cs_sync   <= {cs_sync[0], cs_i};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign sclk_fall = sclk_d & ~sclk_sync[1];
    assign cs_s      = cs_sync[1];

    // Packet type and ID are taken live at bit 0 and held for the rest of the packet
    assign cur_real = (bit_cnt == '0) ? rd_full : pkt_real;
    assign cur_id   = (bit_cnt == '0) ? rd_tag : pkt_id;
    assign id_word  = cur_real ? 16'(cur_id) : discard_id_p;
    assign last_bit = (bit_cnt == bit_w'(total_bits_p - 1));

    always_comb begin
        byte_idx = int'(bit_cnt >> 3);
        pay_idx  = byte_idx - payload_ofs_c;
        rd_addr  = '0;
        tx_byte  = 8'h00;
        if (byte_idx == id_hi_ofs_c || byte_idx == crc_hi_ofs_c) begin
            tx_byte = id_word[15:8];
        end else if (byte_idx == id_lo_ofs_c || byte_idx == crc_lo_ofs_c) begin
            tx_byte = id_word[7:0];
        end else begin
            rd_addr = col_w'(pay_idx / pixel_bytes_p);
            if (cur_real) begin
                tx_byte = 8'(rd_data >> (8 * (pixel_bytes_p - 1 - (pay_idx % pixel_bytes_p))));
            end
        end
    end

    assign tx_bit = tx_byte[~bit_cnt[2:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            pkt_real     <= 1'b0;
            pkt_id       <= '0;
            miso_o       <= 1'b0;
            rd_free      <= 1'b0;
            frame_done_o <= 1'b0;
            flush        <= 1'b0;
        end else begin
            rd_free      <= 1'b0;
            frame_done_o <= 1'b0;
            flush        <= 1'b0;
            if (cs_s) begin
                // Aborting a real packet loses line order, so everything is flushed
                if (state != ST_IDLE && bit_cnt != '0 && pkt_real) begin
                    flush <= 1'b1;
                end
                state   <= ST_IDLE;
                bit_cnt <= '0;
                miso_o  <= 1'b0;
            end else if (sclk_fall) begin
                miso_o <= tx_bit;
                if (bit_cnt == '0) begin
                    pkt_real <= rd_full;
                    pkt_id   <= rd_tag;
                end
                if (last_bit) begin
                    state        <= ST_HDR;
                    bit_cnt      <= '0;
                    rd_free      <= cur_real;
                    frame_done_o <= cur_real && (cur_id == line_w'(frame_packets_p - 1));
                end else begin
                    state   <= (bit_cnt >= bit_w'(hdr_bits_c - 1)) ? ST_PAY : ST_HDR;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    assign busy_o = (state != ST_IDLE) && (bit_cnt != '0);

    assign pixel_ready_o = ~both_full & ~flush;
    assign accept        = pixel_valid_i & pixel_ready_o;
    assign wr_en         = accept & (pixel_sof_i | ~drop);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop <= 1'b1;
        end else if (flush) begin
            drop <= 1'b1;
        end else if (accept && pixel_sof_i) begin
            drop <= 1'b0;
        end
    end

    vospi_line_buffer #(
        .line_pixels_p   (line_pixels_p),
        .frame_packets_p (frame_packets_p),
        .col_w           (col_w),
        .line_w          (line_w)
    ) u_line_buffer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_en_i     (wr_en),
        .wr_sof_i    (pixel_sof_i),
        .wr_data_i   (pixel_i),
        .flush_i     (flush),
        .rd_free_i   (rd_free),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_full_o   (rd_full),
        .rd_tag_o    (rd_tag),
        .both_full_o (both_full)
    );

endmodule

// File: tb/tb_vospi_slave.sv
// Directed-sequence bench for vospi_slave: the bench acts as SPI master and
// pixel source, and checks packets against a line-queue model of the sensor.
`timescale 1ns/1ps
module tb_vospi_slave;

    localparam int PB = 16;
    localparam int FP = 6;
    localparam int LP = (PB - 4) / 2;
    localparam int NB = PB * 8;
    localparam int H  = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        sclk_i;
    logic        cs_i;
    logic        miso_o;
    logic [15:0] pixel_i;
    logic        pixel_valid_i;
    logic        pixel_sof_i;
    logic        pixel_ready_o;
    logic        frame_done_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    int n;
    int aid;

    logic [15:0] exp_pix [$];
    int          exp_id [$];
    int          m_line = 0;
    bit          m_drop = 1'b1;
    logic [7:0]  rx [PB];
    logic [7:0]  eb [PB];

    vospi_slave #(
        .packet_bytes_p  (PB),
        .frame_packets_p (FP),
        .pixel_bytes_p   (2),
        .discard_id_p    (16'h0F00)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sclk_i        (sclk_i),
        .cs_i          (cs_i),
        .miso_o        (miso_o),
        .pixel_i       (pixel_i),
        .pixel_valid_i (pixel_valid_i),
        .pixel_sof_i   (pixel_sof_i),
        .pixel_ready_o (pixel_ready_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (frame_done_o) fd_cnt++;
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_pix(input logic [15:0] pix, input bit sof);
        int w = 0;
        pixel_i = pix;
        pixel_sof_i = sof;
        pixel_valid_i = 1'b1;
        while (!pixel_ready_o && w < 4000) begin
            @(negedge clk_i);
            w++;
        end
        check("push_ready_wait", (w < 4000), 1);
        @(negedge clk_i);
        pixel_valid_i = 1'b0;
        pixel_sof_i = 1'b0;
    endtask

    // Model: a line is kept (and numbered) only if the stream is aligned to a frame
    task automatic feed_line(input bit sof);
        logic [15:0] pix;
        bit keep;
        if (sof) begin
            m_drop = 1'b0;
            m_line = 0;
        end
        keep = !m_drop;
        if (keep) exp_id.push_back(m_line);
        for (int x = 0; x < LP; x++) begin
            pix = 16'($urandom);
            if (keep) exp_pix.push_back(pix);
            push_pix(pix, sof && (x == 0));
        end
        if (keep) m_line = (m_line + 1) % FP;
    endtask

    task automatic model_flush();
        exp_id.delete();
        exp_pix.delete();
        m_drop = 1'b1;
        m_line = 0;
    endtask

    task automatic xfer(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_i);
            sclk_i = 1'b0;
            repeat (H) @(negedge clk_i);
            rx[i / 8][7 - (i % 8)] = miso_o;
            if (i == 40 && nbits == NB) check("busy_mid", busy_o, 1);
            sclk_i = 1'b1;
            if (i != nbits - 1) repeat (H - 1) @(negedge clk_i);
        end
    endtask

    task automatic check_pkt(input bit exp_real, input string tag);
        int id;
        logic [15:0] pix;
        for (int b = 0; b < PB; b++) eb[b] = 8'h00;
        if (exp_real) begin
            check({tag, "_queued"}, (exp_id.size() != 0), 1);
            id = (exp_id.size() != 0) ? exp_id.pop_front() : 0;
            eb[0] = 8'(id >> 8);
            eb[1] = 8'(id);
            eb[2] = eb[0];
            eb[3] = eb[1];
            for (int p = 0; p < LP; p++) begin
                pix = (exp_pix.size() != 0) ? exp_pix.pop_front() : 16'h0000;
                eb[4 + 2 * p] = pix[15:8];
                eb[5 + 2 * p] = pix[7:0];
            end
        end else begin
            eb[0] = 8'h0F;
            eb[2] = 8'h0F;
        end
        for (int b = 0; b < PB; b++) check($sformatf("%s_byte%0d", tag, b), rx[b], eb[b]);
    endtask

    task automatic cs_low();
        @(negedge clk_i);
        cs_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic cs_high();
        @(negedge clk_i);
        cs_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        reset_i = 1'b1;
        sclk_i = 1'b1;
        cs_i = 1'b1;
        pixel_i = '0;
        pixel_valid_i = 1'b0;
        pixel_sof_i = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rst_miso", miso_o, 0);
        check("rst_ready", pixel_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // sclk activity with cs high must not shift anything
        for (int i = 0; i < 8; i++) begin
            sclk_i = ~sclk_i;
            repeat (H) @(negedge clk_i);
            check("idle_miso", miso_o, 0);
            check("idle_busy", busy_o, 0);
        end

        // No pixels: discard packet
        cs_low();
        xfer(NB);
        check_pkt(1'b0, "discard0");
        cs_high();
        check("discard0_frame_done", fd_cnt, 0);

        // Full frame with concurrent feeding, then a discard
        feed_line(1'b1);
        feed_line(1'b0);
        cs_low();
        fork
            begin
                for (int l = 2; l < FP; l++) feed_line(1'b0);
            end
            begin
                for (int p = 0; p < FP; p++) begin
                    xfer(NB);
                    check_pkt(1'b1, $sformatf("frame_p%0d", p));
                end
                xfer(NB);
                check_pkt(1'b0, "frame_after");
            end
        join
        cs_high();
        check("frame_done_count", fd_cnt, 1);
        check("frame_ready", pixel_ready_o, 1);

        // Master stalled: two wrapped lines fill both buffers
        feed_line(1'b0);
        feed_line(1'b0);
        check("stall_ready_low", pixel_ready_o, 0);
        cs_low();
        xfer(NB);
        n = 0;
        while (!pixel_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("stall_ready_return", (n <= 2), 1);
        check_pkt(1'b1, "stall_p0");
        feed_line(1'b0);
        xfer(NB);
        check_pkt(1'b1, "stall_p1");
        xfer(NB);
        check_pkt(1'b1, "stall_p2");
        cs_high();

        // SOF realign from line 3, then abort during the last line's payload
        feed_line(1'b1);
        feed_line(1'b0);
        cs_low();
        fork
            begin
                for (int l = 2; l < FP; l++) feed_line(1'b0);
            end
            begin
                for (int p = 0; p < FP - 1; p++) begin
                    xfer(NB);
                    check_pkt(1'b1, $sformatf("realign_p%0d", p));
                end
            end
        join
        xfer(100);
        cs_high();
        aid = (exp_id.size() != 0) ? exp_id.pop_front() : -1;
        check("abort_header", {rx[0], rx[1], rx[2], rx[3]}, {16'(aid), 16'(aid)});
        model_flush();
        check("abort_miso", miso_o, 0);
        check("abort_ready", pixel_ready_o, 1);
        for (int l = 0; l < 3; l++) feed_line(1'b0);
        check("drop_ready", pixel_ready_o, 1);
        cs_low();
        xfer(NB);
        check_pkt(1'b0, "abort_discard");
        cs_high();
        feed_line(1'b1);
        feed_line(1'b0);
        cs_low();
        xfer(NB);
        check_pkt(1'b1, "refeed_p0");
        xfer(NB);
        check_pkt(1'b1, "refeed_p1");
        cs_high();

        // Reset asserted during a payload
        feed_line(1'b1);
        feed_line(1'b0);
        cs_low();
        fork
            begin
                for (int l = 2; l < 4; l++) feed_line(1'b0);
            end
            begin
                for (int p = 0; p < 3; p++) begin
                    xfer(NB);
                    check_pkt(1'b1, $sformatf("prerst_p%0d", p));
                end
            end
        join
        xfer(60);
        @(negedge clk_i);
        sclk_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check("midrst_miso", miso_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", pixel_ready_o, 1);
        sclk_i = 1'b1;
        cs_i = 1'b1;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        model_flush();
        repeat (4) @(negedge clk_i);
        cs_low();
        xfer(NB);
        check_pkt(1'b0, "postrst_discard");
        cs_high();
        feed_line(1'b1);
        feed_line(1'b0);
        cs_low();
        xfer(NB);
        check_pkt(1'b1, "postrst_p0");
        xfer(NB);
        check_pkt(1'b1, "postrst_p1");
        cs_high();
        check("end_frame_done_count", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
